ifid_buffer: RTL and testbench
==============================

# ifid_buffer

Fetch-to-decode pipeline stage: a small registered instruction buffer between the fetch stage (`instrF`, `pcplus4F`) and the decode stage. It decouples decode stalls from fetch by holding up to `DEPTH` fetched words and asserts `stallF` back to fetch only when full. It also discards all buffered and in-flight words on a taken branch or jump (`flushD`). When empty, it presents a NOP with `validD` low.

## Interface
- `DEPTH`, 2 — entries; power of two, ≥ 2.
- `NOP`, 32'h00000000 — instruction word driven on `instrD` when empty.

- `clk` in 1 — rising-edge clock.
- `reset` in 1 — synchronous, active-low. Sampled at `posedge clk`; `reset==0` clears state.
- `instrF` in 32 — fetched instruction.
- `pcplus4F` in 32 — fetched PC+4.
- `fetchValid` in 1 — fetch word is meaningful this cycle.
- `stallD` in 1 — decode cannot accept the head entry this cycle.
- `flushD` in 1 — branch/jump redirect; discard everything.
- `stallF` out 1 — buffer full; fetch must hold its PC.
- `instrD` out 32 — head instruction, or `NOP` when empty.
- `pcplus4D` out 32 — head PC+4, or 0 when empty.
- `validD` out 1 — head entry present.

## Operation
- **Storage:** `DEPTH` entries of {instr, pcplus4}, with `wrPtr`, `rdPtr` (log2 `DEPTH` bits, wrap modulo `DEPTH`) and `count` (0..`DEPTH`).
- **Enqueue:** `enq = fetchValid & !stallF & !flushD`. Writes `instrF`/`pcplus4F` at `wrPtr`, then increments `wrPtr`.
- **Dequeue:** `deq = validD & !stallD & !flushD`. Increments `rdPtr`.
- **Count update:** `count += enq - deq`. Simultaneous `enq` and `deq` leaves `count` unchanged and is legal whenever `count` < `DEPTH`.
- **Stall:** `stallF = (count == DEPTH)`, combinational from registered `count` only, with no path from `stallD`. At full, `enq` is impossible and `deq` frees a slot for the next cycle.
- **Outputs:** `validD = (count != 0)`. `instrD`/`pcplus4D` come from entry `rdPtr` when `validD`, else `NOP`/0.
- **Flush:** `flushD==1` at an edge sets `count`, `wrPtr` and `rdPtr` to 0. The current fetch word is dropped. `flushD` overrides `stallD`.
- **Reset priority:** reset > flush > enq/deq.
- **Reset values:** `count=0`, `wrPtr=0`, `rdPtr=0`. After reset, outputs are `validD=0`, `stallF=0`, `instrD=NOP`, `pcplus4D=0`. Entry contents are don't-care.

## Timing
- Latency is 1 cycle: a word enqueued at edge N appears on `instrD` after edge N, if the buffer was empty.
- Throughput is 1 word/cycle with `stallD=0`. Steady state holds `count=1`.
- `stallF` rises the cycle after the edge that fills the buffer. It falls the cycle after the first dequeue from full.
- Reset mid-operation: buffered words are lost, and outputs take reset values the cycle after the reset edge.
- Flush while full: `stallF=0` and `validD=0` the next cycle.

## Configuration
- **With `IFID_PERF_EN` defined:** adds two 32-bit outputs, `bubbleCount` and `fullCount`.
  - `bubbleCount` increments each edge with `reset==1` and `validD==0`.
  - `fullCount` increments each edge with `reset==1` and `stallF==1`.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- **Without `IFID_PERF_EN`:** those ports and their logic are absent; all other behaviour is identical.

## Test plan
- **Reset:** hold `reset=0` 2 cycles with `fetchValid=1` → `validD=0`, `instrD=32'h0`, `pcplus4D=0`, `stallF=0`.
- **Streaming:** feed `instrF` = 32'h20020005, 32'h2003000C, 32'h2067FFF7 with `pcplus4F` = 4, 8, 12 and `stallD=0` → identical sequence on `instrD`/`pcplus4D` one cycle later, `validD` continuously 1, `stallF=0`.
- **Fill:** `stallD=1` for 4 cycles while streaming → `count` reaches 2, `stallF=1` from the third cycle. Release `stallD` → the two buffered words emerge in order, nothing is lost or duplicated, then `stallF=0`.
- **Flush:** full buffer plus `flushD=1` for one cycle with `stallD=1` and `fetchValid=1` → next cycle `validD=0`, `stallF=0`. The word after the flush enters normally.
- **Wrap-around:** 10 words with `stallD` toggling every other cycle → output order matches input order across pointer wrap.
- **Perf (`IFID_PERF_EN` defined):** reset, then 3 empty cycles and 2 full cycles → `bubbleCount=3`, `fullCount=2`.

Source files
------------

// File: rtl/ifid_buffer.sv
// Fetch-to-decode instruction buffer: DEPTH-entry FIFO of {instr, pcplus4} with flush and full-stall.
// Optional perf counters (bubbleCount, fullCount) are enabled by defining IFID_PERF_EN.
module ifid_buffer #(
    parameter int unsigned DEPTH = 2,
    parameter logic [31:0] NOP   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instrF,
    input  logic [31:0] pcplus4F,
    input  logic        fetchValid,
    input  logic        stallD,
    input  logic        flushD,
    output logic        stallF,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD
`ifdef IFID_PERF_EN
    ,
    output logic [31:0] bubbleCount,
    output logic [31:0] fullCount
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_mem_q [DEPTH];
    logic [31:0]   pc_mem_q    [DEPTH];
    logic          enq, deq;

    // stallF depends on registered count only, so decode stalls never reach fetch combinationally
    assign stallF = (count_q == CW'(DEPTH));
    assign validD = (count_q != '0);
    assign enq    = fetchValid & ~stallF & ~flushD;
    assign deq    = validD & ~stallD & ~flushD;

    assign instrD   = validD ? instr_mem_q[rd_ptr_q] : NOP;
    assign pcplus4D = validD ? pc_mem_q[rd_ptr_q]    : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flushD) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
            if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; validity is tracked by count_q alone
    always_ff @(posedge clk) begin
        if (enq) begin
            instr_mem_q[wr_ptr_q] <= instrF;
            pc_mem_q[wr_ptr_q]    <= pcplus4F;
        end
    end

`ifdef IFID_PERF_EN
    logic [31:0] bubble_q, full_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            bubble_q <= '0;
            full_q   <= '0;
        end else begin
            if (!validD && bubble_q != '1) bubble_q <= bubble_q + 32'd1;
            if (stallF && full_q != '1)    full_q   <= full_q + 32'd1;
        end
    end

    assign bubbleCount = bubble_q;
    assign fullCount   = full_q;
`endif

endmodule

// File: tb/tb_ifid_buffer.sv
// Testbench for ifid_buffer: directed and random steps checked against a queue-based reference model.
// Define IFID_PERF_EN to also check the perf counters.
module tb_ifid_buffer;

    localparam int unsigned DEPTH = 2;
    localparam logic [31:0] NOPW  = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic [31:0] instrF;
    logic [31:0] pcplus4F;
    logic        fetchValid;
    logic        stallD;
    logic        flushD;
    logic        stallF;
    logic [31:0] instrD;
    logic [31:0] pcplus4D;
    logic        validD;
`ifdef IFID_PERF_EN
    logic [31:0] bubbleCount;
    logic [31:0] fullCount;
`endif

    ifid_buffer #(.DEPTH(DEPTH), .NOP(NOPW)) dut (
        .clk        (clk),
        .reset      (reset),
        .instrF     (instrF),
        .pcplus4F   (pcplus4F),
        .fetchValid (fetchValid),
        .stallD     (stallD),
        .flushD     (flushD),
        .stallF     (stallF),
        .instrD     (instrD),
        .pcplus4D   (pcplus4D),
        .validD     (validD)
`ifdef IFID_PERF_EN
        ,
        .bubbleCount(bubbleCount),
        .fullCount  (fullCount)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [31:0] m_bub = '0;
    logic [31:0] m_full = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare outputs
    task automatic step(input logic rst, input logic fv, input logic sd, input logic fl,
                        input logic [31:0] ins, input logic [31:0] pc);
        bit was_full, was_valid, d, e;
        ent_t ne;
        reset = rst; fetchValid = fv; stallD = sd; flushD = fl;
        instrF = ins; pcplus4F = pc;
        @(posedge clk);
        was_full  = (mq.size() == DEPTH);
        was_valid = (mq.size() != 0);
        if (!rst) begin
            m_bub = '0;
            m_full = '0;
        end else begin
            if (!was_valid && m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 1;
            if (was_full && m_full != 32'hFFFF_FFFF) m_full = m_full + 1;
        end
        if (!rst || fl) begin
            mq.delete();
        end else begin
            d = was_valid && !sd;
            e = fv && !was_full;
            if (d) void'(mq.pop_front());
            if (e) begin
                ne.ins = ins;
                ne.pc  = pc;
                mq.push_back(ne);
            end
        end
        #1;
        chk("validD", {31'b0, validD}, {31'b0, mq.size() != 0});
        chk("stallF", {31'b0, stallF}, {31'b0, mq.size() == DEPTH});
        chk("instrD", instrD, (mq.size() != 0) ? mq[0].ins : NOPW);
        chk("pcplus4D", pcplus4D, (mq.size() != 0) ? mq[0].pc : 32'h0);
`ifdef IFID_PERF_EN
        chk("bubbleCount", bubbleCount, m_bub);
        chk("fullCount", fullCount, m_full);
`endif
    endtask

    logic [31:0] words [3];

    initial begin
        words[0] = 32'h20020005;
        words[1] = 32'h2003000C;
        words[2] = 32'h2067FFF7;

        // reset held two cycles with fetch active
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h100);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h104);
        chk("reset_instrD", instrD, 32'h0);
        chk("reset_stallF", {31'b0, stallF}, 32'h0);

        // streaming
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 1'b0, 1'b0, words[i], 32'(4 * (i + 1)));
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // fill under decode stall, then drain
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h1000 + 32'(i), 32'h40 + 32'(4 * i));
        chk("fill_stallF", {31'b0, stallF}, 32'h1);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // flush while full
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hA1, 32'h200);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hA2, 32'h204);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hA3, 32'h208);
        chk("flush_validD", {31'b0, validD}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'hA4, 32'h20C);
        chk("postflush_instrD", instrD, 32'hA4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // wrap-around with toggling decode stall
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 1'(i % 2), 1'b0, 32'hC000 + 32'(i), 32'h300 + 32'(4 * i));
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

`ifdef IFID_PERF_EN
        // perf: reset, 3 empty cycles, then fill and hold full 2 cycles
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        chk("perf_bubble3", bubbleCount, 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hE0, 32'h500);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hE1, 32'h504);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hE2, 32'h508);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'hE3, 32'h50C);
        chk("perf_full2", fullCount, 32'd2);
`endif

        // randomized traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 49) != 0), 1'($urandom), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 11) == 0), $urandom, $urandom);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
